// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel frame writer slice.
// Holds the default image geometry, the frame-buffer address width, the
// RGB565 word width, the writer FSM state encoding and the pixel packing
// helper used by the top level.
package sobel_pkg;

  localparam int IMG_WIDTH  = 320;
  localparam int IMG_HEIGHT = 240;
  localparam int ADDR_W     = 17;
  localparam int RGB565_W   = 16;

  // Writer FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Truncate 8:8:8 to 5:6:5 by keeping the most significant bits of each channel
  function automatic logic [RGB565_W-1:0] pack_rgb565(input logic [7:0] red,
                                                      input logic [7:0] green,
                                                      input logic [7:0] blue);
    return {red[7:3], green[7:2], blue[7:3]};
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO holding {address, RGB565} entries for the frame writer.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push, push_data write an entry (ignored when full unless popping too)
//   pop             remove the head entry (ignored when empty)
//   head            current head entry (valid while !empty)
//   full, empty     occupancy flags
// Push and pop in the same cycle are both honoured at any fill level.
module pixel_fifo #(
  parameter int WIDTH = sobel_pkg::ADDR_W + sobel_pkg::RGB565_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign empty     = (count_r == {(PTR_W+1){1'b0}});
  assign full      = (count_r == CNT_FULL);
  assign pop_ok_s  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok_s = push && (!full || pop_ok_s);
  assign head      = mem_r[rd_ptr_r];

  // Storage array; cleared on reset so the head reads as zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Read/write pointers and occupancy count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sobel_frame_writer.sv
// Captures one frame of Sobel edge pixels into a frame buffer.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   sobel_red/green/blue_i      8-bit pixel channels, valid with sobel_done_i
//   sobel_done_i                one-cycle pixel strobe
//   frame_start_i               request to capture the next frame (IDLE only)
//   mem_ready_i                 frame buffer accepts a write this cycle
//   wr_en_o/wr_addr_o/wr_data_o write request, linear address, RGB565 data
//   busy_o                      high outside IDLE
//   frame_done_o                one-cycle end-of-frame pulse
//   overflow_o                  sticky: a pixel was dropped this frame
// Pixels are queued in a small FIFO so the frame buffer may stall; every
// strobe advances the address even if its pixel had to be dropped.
module sobel_frame_writer #(
  parameter int IMG_WIDTH  = sobel_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = sobel_pkg::IMG_HEIGHT,
  parameter int ADDR_W     = sobel_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        sobel_red_i,
  input  logic [7:0]        sobel_green_i,
  input  logic [7:0]        sobel_blue_i,
  input  logic              sobel_done_i,
  input  logic              frame_start_i,
  input  logic              mem_ready_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [15:0]       wr_data_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              overflow_o
);
  import sobel_pkg::*;

  localparam int ENTRY_W = ADDR_W + RGB565_W;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]         state_r;
  logic [1:0]         state_next_s;
  logic [ADDR_W-1:0]  pix_cnt_r;
  logic               overflow_r;
  logic               start_s;
  logic               strobe_s;
  logic               pop_s;
  logic               push_s;
  logic               drop_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [ENTRY_W-1:0] push_data_s;
  logic [ENTRY_W-1:0] head_s;

  assign start_s     = (state_r == ST_IDLE) && frame_start_i;
  assign strobe_s    = (state_r == ST_ACTIVE) && sobel_done_i;
  assign pop_s       = !fifo_empty_s && mem_ready_i;
  assign push_s      = strobe_s && (!fifo_full_s || pop_s);
  assign drop_s      = strobe_s && fifo_full_s && !pop_s;
  assign push_data_s = {pix_cnt_r, pack_rgb565(sobel_red_i, sobel_green_i, sobel_blue_i)};

  pixel_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_pixel_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Next-state decode for the capture FSM
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (frame_start_i) begin
          state_next_s = ST_ACTIVE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (strobe_s && (pix_cnt_r == LAST_PIX)) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_ACTIVE;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty_s && !pop_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Pixel counter: advances on every accepted strobe, stored or dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt_r <= {ADDR_W{1'b0}};
    end else if (start_s) begin
      pix_cnt_r <= {ADDR_W{1'b0}};
    end else if (strobe_s) begin
      pix_cnt_r <= (pix_cnt_r == LAST_PIX) ? {ADDR_W{1'b0}} : pix_cnt_r + CNT_ONE;
    end else begin
      pix_cnt_r <= pix_cnt_r;
    end
  end

  // Sticky overflow flag, cleared only by an accepted frame start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r <= 1'b0;
    end else if (start_s) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign wr_en_o      = !fifo_empty_s;
  assign wr_addr_o    = head_s[ENTRY_W-1:RGB565_W];
  assign wr_data_o    = head_s[RGB565_W-1:0];
  assign busy_o       = (state_r != ST_IDLE);
  assign frame_done_o = (state_r == ST_DONE);
  assign overflow_o   = overflow_r;

endmodule

// File: tb/tb_sobel_frame_writer.sv
// Directed self-checking bench for sobel_frame_writer (4x2 image, 4-deep FIFO).
module tb_sobel_frame_writer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 4;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    sobel_red_i;
  logic [7:0]    sobel_green_i;
  logic [7:0]    sobel_blue_i;
  logic          sobel_done_i;
  logic          frame_start_i;
  logic          mem_ready_i;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [15:0]   wr_data_o;
  logic          busy_o;
  logic          frame_done_o;
  logic          overflow_o;

  always #5 clk = ~clk;

  sobel_frame_writer #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .ADDR_W     (AW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sobel_red_i   (sobel_red_i),
    .sobel_green_i (sobel_green_i),
    .sobel_blue_i  (sobel_blue_i),
    .sobel_done_i  (sobel_done_i),
    .frame_start_i (frame_start_i),
    .mem_ready_i   (mem_ready_i),
    .wr_en_o       (wr_en_o),
    .wr_addr_o     (wr_addr_o),
    .wr_data_o     (wr_data_o),
    .busy_o        (busy_o),
    .frame_done_o  (frame_done_o),
    .overflow_o    (overflow_o)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int wa_q[$];
  int wd_q[$];
  int wc_q[$];

  // Monitor: log every completed write and every frame_done cycle
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (wr_en_o === 1'b1 && mem_ready_i === 1'b1) begin
      wa_q.push_back(int'(wr_addr_o));
      wd_q.push_back(int'(wr_data_o));
      wc_q.push_back(cyc);
    end
    if (frame_done_o === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  function automatic logic [15:0] pk(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

  function automatic logic [7:0] pr(input int i); return 8'(i * 33 + 5);  endfunction
  function automatic logic [7:0] pg(input int i); return 8'(i * 19 + 70); endfunction
  function automatic logic [7:0] pb(input int i); return 8'(255 - i * 7); endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pix(input int i);
    sobel_red_i   = pr(i);
    sobel_green_i = pg(i);
    sobel_blue_i  = pb(i);
    sobel_done_i  = 1'b1;
    step();
    sobel_done_i  = 1'b0;
  endtask

  task automatic start();
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    int n = 0;
    while (done_cnt == base && n < 40) begin
      step();
      n++;
    end
    step();
    step();
    chk(tag, 32'(done_cnt - base), 32'd1);
  endtask

  task automatic chk_write(input string tag, input int idx, input int exp_addr);
    if (idx < wa_q.size()) begin
      chk(tag, 32'(wa_q[idx]), 32'(exp_addr));
    end else begin
      chk(tag, 32'hFFFF_FFFF, 32'(exp_addr));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int db;
    int last_wc;
    rst = 1'b0;
    sobel_red_i = 8'h00; sobel_green_i = 8'h00; sobel_blue_i = 8'h00;
    sobel_done_i = 1'b0; frame_start_i = 1'b0; mem_ready_i = 1'b1;
    step(); step();
    chk("rst_wr_en", 32'(wr_en_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(frame_done_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_addr", 32'(wr_addr_o), 32'd0);
    chk("rst_data", 32'(wr_data_o), 32'd0);
    rst = 1'b1;
    step();

    // Nominal frame, memory always ready
    base = wa_q.size(); db = done_cnt;
    start();
    chk("nom_busy", 32'(busy_o), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        sobel_red_i = 8'hFF; sobel_green_i = 8'h80; sobel_blue_i = 8'h0F;
        sobel_done_i = 1'b1;
        step();
        sobel_done_i = 1'b0;
        chk("nom_data_fc01", 32'(wr_data_o), 32'h0000_FC01);
      end else begin
        pix(i);
        chk("nom_data", 32'(wr_data_o), 32'(pk(pr(i), pg(i), pb(i))));
      end
      chk("nom_head_addr", 32'(wr_addr_o), 32'(i));
      chk("nom_wr_en", 32'(wr_en_o), 32'd1);
    end
    wait_done(db, "nom_done_once");
    last_wc = (wc_q.size() > 0) ? wc_q[wc_q.size()-1] : 0;
    chk("nom_done_lat", 32'(done_cyc - last_wc), 32'd2);
    chk("nom_nwrites", 32'(wa_q.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) chk_write("nom_addr", base + i, i);
    chk("nom_idle", 32'(busy_o), 32'd0);

    // Spurious controls: strobes in IDLE, frame_start while ACTIVE
    base = wa_q.size(); db = done_cnt;
    pix(0); pix(1); pix(2);
    step();
    chk("sp_idle_nowr", 32'(wa_q.size() - base), 32'd0);
    chk("sp_idle_busy", 32'(busy_o), 32'd0);
    start();
    pix(0); pix(1); pix(2);
    frame_start_i = 1'b1;
    pix(3);
    frame_start_i = 1'b0;
    for (int i = 4; i < 8; i++) pix(i);
    wait_done(db, "sp_done_once");
    chk("sp_nwrites", 32'(wa_q.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) chk_write("sp_addr", base + i, i);

    // Backpressure: 10 cycles not ready, 4 strobes fill the FIFO
    base = wa_q.size(); db = done_cnt;
    mem_ready_i = 1'b0;
    start();
    for (int i = 0; i < 4; i++) pix(i);
    for (int k = 0; k < 6; k++) begin
      chk("bp_wr_en", 32'(wr_en_o), 32'd1);
      chk("bp_addr_hold", 32'(wr_addr_o), 32'd0);
      chk("bp_data_hold", 32'(wr_data_o), 32'(pk(pr(0), pg(0), pb(0))));
      step();
    end
    chk("bp_no_ovf", 32'(overflow_o), 32'd0);
    chk("bp_nowr", 32'(wa_q.size() - base), 32'd0);
    mem_ready_i = 1'b1;
    step(); step(); step(); step();
    chk("bp_drained", 32'(wr_en_o), 32'd0);
    chk("bp_nwrites", 32'(wa_q.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) chk_write("bp_addr", base + i, i);
    if (wc_q.size() >= base + 4) begin
      chk("bp_consecutive", 32'(wc_q[base+3] - wc_q[base]), 32'd3);
    end else begin
      chk("bp_consecutive", 32'(wc_q.size()), 32'(base + 4));
    end
    for (int i = 4; i < 8; i++) pix(i);
    wait_done(db, "bp_done_once");

    // Overflow: fifth strobe with full FIFO and no pop is dropped
    base = wa_q.size(); db = done_cnt;
    mem_ready_i = 1'b0;
    start();
    for (int i = 0; i < 4; i++) pix(i);
    chk("ov_not_yet", 32'(overflow_o), 32'd0);
    pix(4);
    chk("ov_set", 32'(overflow_o), 32'd1);
    chk("ov_head", 32'(wr_addr_o), 32'd0);
    mem_ready_i = 1'b1;
    step(); step(); step(); step();
    for (int i = 5; i < 8; i++) pix(i);
    wait_done(db, "ov_done_once");
    chk("ov_nwrites", 32'(wa_q.size() - base), 32'd7);
    chk_write("ov_a0", base + 0, 0);
    chk_write("ov_a3", base + 3, 3);
    chk_write("ov_skip4", base + 4, 5);
    chk_write("ov_a6", base + 5, 6);
    chk_write("ov_a7", base + 6, 7);
    chk("ov_sticky", 32'(overflow_o), 32'd1);

    // Full FIFO with simultaneous push and pop
    db = done_cnt;
    mem_ready_i = 1'b0;
    start();
    chk("ov_cleared", 32'(overflow_o), 32'd0);
    for (int i = 0; i < 4; i++) pix(i);
    mem_ready_i = 1'b1;
    pix(4);
    mem_ready_i = 1'b0;
    chk("pp_no_ovf", 32'(overflow_o), 32'd0);
    chk("pp_head", 32'(wr_addr_o), 32'd1);
    base = wa_q.size();
    mem_ready_i = 1'b1;
    step(); step(); step();
    chk("pp_still_one", 32'(wr_en_o), 32'd1);
    step();
    chk("pp_empty", 32'(wr_en_o), 32'd0);
    chk("pp_nwrites", 32'(wa_q.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) chk_write("pp_addr", base + i, i + 1);
    for (int i = 5; i < 8; i++) pix(i);
    wait_done(db, "pp_done_once");

    // Reset mid-frame with three queued entries
    db = done_cnt;
    mem_ready_i = 1'b0;
    start();
    pix(0); pix(1); pix(2);
    chk("mr_pre_wr_en", 32'(wr_en_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mr_wr_en", 32'(wr_en_o), 32'd0);
    chk("mr_busy", 32'(busy_o), 32'd0);
    chk("mr_done", 32'(frame_done_o), 32'd0);
    chk("mr_ovf", 32'(overflow_o), 32'd0);
    chk("mr_addr", 32'(wr_addr_o), 32'd0);
    chk("mr_data", 32'(wr_data_o), 32'd0);
    step();
    rst = 1'b1;
    mem_ready_i = 1'b1;
    base = wa_q.size();
    pix(3); pix(4);
    step(); step();
    chk("mr_ignored", 32'(wa_q.size() - base), 32'd0);
    chk("mr_idle", 32'(busy_o), 32'd0);
    chk("mr_no_done", 32'(done_cnt - db), 32'd0);
    start();
    for (int i = 0; i < 8; i++) pix(i);
    wait_done(db, "mr_done_once");
    chk("mr_nwrites", 32'(wa_q.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) chk_write("mr_addr", base + i, i);
    if (wd_q.size() > base + 7) begin
      chk("mr_last_data", 32'(wd_q[base+7]), 32'(pk(pr(7), pg(7), pb(7))));
    end else begin
      chk("mr_last_data", 32'(wd_q.size()), 32'(base + 8));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sobel_frame_writer.md
SOBEL_FRAME_WRITER -- requirements
Module: sobel_frame_writer

Interface
REQ-001 Parameter IMG_WIDTH, default 320, pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 240, lines per frame.
REQ-003 Parameter ADDR_W, default 17, frame-buffer address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT.
REQ-004 Parameter FIFO_DEPTH, default 4, power of two, minimum 2.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-low.
REQ-007 sobel_red_i, sobel_green_i, sobel_blue_i  input  8 each  edge-image pixel from the Sobel stage.
REQ-008 sobel_done_i  input  1  one-cycle pixel-valid strobe accompanying the RGB inputs.
REQ-009 frame_start_i  input  1  one-cycle request to capture the next frame.
REQ-010 mem_ready_i  input  1  frame-buffer accepts a write this cycle.
REQ-011 wr_en_o  output  1  write request.
REQ-012 wr_addr_o  output  ADDR_W  linear pixel address.
REQ-013 wr_data_o  output  16  RGB565 pixel.
REQ-014 busy_o  output  1  high in every state other than IDLE.
REQ-015 frame_done_o  output  1  one-cycle end-of-frame pulse.
REQ-016 overflow_o  output  1  sticky pixel-dropped flag.

Function
REQ-017 FSM states: IDLE, ACTIVE, DRAIN, DONE.
REQ-018 Transitions:
- IDLE->ACTIVE on frame_start_i; also clears the pixel counter and overflow_o.
- ACTIVE->DRAIN on the cycle the IMG_WIDTH*IMG_HEIGHT-th strobe is counted.
- DRAIN->DONE when the FIFO is empty and no write completes this cycle.
- DONE->IDLE unconditionally.
REQ-019 frame_start_i outside IDLE shall be ignored.
REQ-020 sobel_done_i outside ACTIVE shall be ignored; the counter and FIFO stay unchanged.
REQ-021 Each strobe in ACTIVE shall increment the pixel counter (0..IMG_WIDTH*IMG_HEIGHT-1) whether or not the pixel is stored.
REQ-022 Each stored pixel shall be pushed as a {counter value, RGB565} entry.
REQ-023 RGB565 packing shall be {red[7:3], green[7:2], blue[7:3]}.
REQ-024 wr_en_o shall equal FIFO not-empty.
REQ-025 wr_addr_o and wr_data_o shall present the FIFO head.
REQ-026 A write completes, and the head pops, on a cycle where wr_en_o && mem_ready_i.
REQ-027 Latency: a pixel pushed into an empty FIFO at edge N shall appear on wr_en_o/wr_addr_o/wr_data_o in the cycle after edge N.
REQ-028 wr_addr_o and wr_data_o shall hold stable while wr_en_o is high and mem_ready_i is low.
REQ-029 Simultaneous push and pop shall be legal at any fill level, including full; occupancy is then unchanged.
REQ-030 A strobe while the FIFO is full and no pop occurs shall drop the pixel and set overflow_o.
REQ-031 overflow_o shall hold until the next accepted frame_start_i.
REQ-032 frame_done_o shall be high exactly during DONE.
REQ-033 Writes shall retire in strict address-increasing order; no address may be written twice per frame.

Reset
REQ-034 While rst is low:
- state = IDLE; counter = 0; FIFO empty.
- wr_en_o, busy_o, frame_done_o and overflow_o are 0.
- wr_addr_o and wr_data_o are 0.
REQ-035 Reset asserted mid-frame shall abort the frame immediately and discard FIFO contents, with no frame_done_o.
REQ-036 Release shall resume in IDLE, requiring a new frame_start_i.

Structure
REQ-037 Shared package sobel_pkg shall hold IMG_WIDTH, IMG_HEIGHT, ADDR_W, the RGB565 width constant and the FSM state encoding.
REQ-038 Storage shall be one sub-module, pixel_fifo: synchronous FIFO of width ADDR_W+16 and depth FIFO_DEPTH, with full/empty outputs and same-cycle push/pop.
REQ-039 The FSM, counter and packing logic shall reside in sobel_frame_writer.

Verification
REQ-040 Reset: rst low mid-ACTIVE with 3 FIFO entries -> all outputs 0 within the same cycle; after release, strobes are ignored until frame_start_i.
REQ-041 Nominal: IMG_WIDTH=4, IMG_HEIGHT=2, mem_ready_i=1, 8 strobes 1 cycle apart -> addresses 0..7 in order.
  - Pixel R=FF,G=80,B=0F -> wr_data_o=0xFC01.
  - frame_done_o pulses once, 2 cycles after the last write.
REQ-042 Backpressure: mem_ready_i=0 for 10 cycles while 4 strobes arrive -> FIFO full, outputs stable, no overflow; on release the 4 writes retire consecutively.
REQ-043 Overflow: 5th strobe with FIFO full and mem_ready_i=0 -> overflow_o=1, address 4 never written, next pixel written at address 5; overflow_o clears on the next frame_start_i.
REQ-044 Full push+pop: FIFO full, mem_ready_i=1 and a strobe in the same cycle -> no overflow, occupancy stays at FIFO_DEPTH.
REQ-045 Spurious controls: frame_start_i during ACTIVE and strobes in IDLE -> no effect on counter, writes or frame_done_o.
